// File: rtl/dsp_alu_pkg.sv
// Shared types and constants for the sail-core DSP-ALU slice.
`timescale 1ns/1ps
package dsp_alu_pkg;

  localparam int unsigned HALF_W = 32;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/add_half_step.sv
// One HALF_W-bit add/sub pass; B is inverted internally for subtraction.
`timescale 1ns/1ps
module add_half_step
  import dsp_alu_pkg::*;
#(
  parameter int unsigned W = HALF_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b ^ {W{sub}}} + {{W{1'b0}}, cin};
    sum  = full[W-1:0];
    cout = full[W];
  end

endmodule

// File: rtl/dsp_add64_seq.sv
// Two-pass 64-bit add/sub sequencer with valid/ready on both sides.
`timescale 1ns/1ps
module dsp_add64_seq #(
  parameter int unsigned HALF_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*HALF_W-1:0]   op_a,
  input  logic [2*HALF_W-1:0]   op_b,
  input  logic                  is_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*HALF_W-1:0]   result,
  output logic                  carry_out,
  output logic                  overflow,
  output logic                  busy
);
  import dsp_alu_pkg::*;

  localparam int unsigned FULL_W = 2 * HALF_W;

  state_t              state_q, state_d;
  logic [FULL_W-1:0]   a_q, b_q;
  logic                sub_q;
  logic                c_mid_q;
  logic [FULL_W-1:0]   result_q;
  logic                carry_q;
  logic                ovf_q;

  logic                accept;
  logic                hi_pass;
  logic [HALF_W-1:0]   step_a, step_b, step_sum;
  logic                step_cin, step_cout;

  // flush wins over acceptance, so in_ready is masked by it
  assign in_ready  = (state_q == IDLE) && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = LO;
      LO:      state_d = HI;
      HI:      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // One adder serves both passes; the low pass takes sub as its carry-in
  always_comb begin
    hi_pass  = (state_q == HI);
    step_a   = hi_pass ? a_q[FULL_W-1:HALF_W] : a_q[HALF_W-1:0];
    step_b   = hi_pass ? b_q[FULL_W-1:HALF_W] : b_q[HALF_W-1:0];
    step_cin = hi_pass ? c_mid_q : sub_q;
  end

  add_half_step #(.W(HALF_W)) u_step (
    .a    (step_a),
    .b    (step_b),
    .sub  (sub_q),
    .cin  (step_cin),
    .sum  (step_sum),
    .cout (step_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= OP_ADD;
      c_mid_q  <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= op_a;
        b_q   <= op_b;
        sub_q <= is_sub;
      end
      if (!flush && state_q == LO) begin
        result_q[HALF_W-1:0] <= step_sum;
        c_mid_q              <= step_cout;
      end
      if (!flush && state_q == HI) begin
        result_q[FULL_W-1:HALF_W] <= step_sum;
        carry_q <= step_cout ^ sub_q;
        ovf_q   <= (a_q[FULL_W-1] == (b_q[FULL_W-1] ^ sub_q)) &&
                   (step_sum[HALF_W-1] != a_q[FULL_W-1]);
      end
    end
  end

endmodule

// File: tb/tb_dsp_add64_seq.sv
// Self-checking bench for dsp_add64_seq: directed table, corner sequences, random ops.
`timescale 1ns/1ps
module tb_dsp_add64_seq;

  localparam int unsigned HALF_W = 32;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, is_sub;
  logic        out_valid, out_ready, carry_out, overflow, busy;
  logic [63:0] op_a, op_b, result;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic [63:0] res;
    logic        co;
    logic        ov;
  } vec_t;

  always #5 clk = ~clk;

  dsp_add64_seq #(.HALF_W(HALF_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .is_sub    (is_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  // Reference: 65-bit unsigned and signed arithmetic on the whole operands
  function automatic vec_t model(input logic [63:0] a, input logic [63:0] b, input logic sub);
    vec_t             v;
    logic [64:0]        u;
    logic signed [64:0] s;
    v.a = a; v.b = b; v.sub = sub;
    if (sub) begin
      u    = {1'b0, a} - {1'b0, b};
      s    = $signed({a[63], a}) - $signed({b[63], b});
      v.co = (a < b);
    end else begin
      u    = {1'b0, a} + {1'b0, b};
      s    = $signed({a[63], a}) + $signed({b[63], b});
      v.co = u[64];
    end
    v.res = u[63:0];
    v.ov  = (s[64] != s[63]);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one op, returns 1 ns after the accept edge with junk on the operand bus
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic sub);
    int guard = 0;
    op_a = a; op_b = b; is_sub = sub; in_valid = 1'b1;
    while (!in_ready && guard < 20) begin step(); guard++; end
    if (!in_ready) chk("issue_timeout", 64'd0, 64'd1);
    step();
    in_valid = 1'b0;
    op_a     = {$urandom, $urandom};
    op_b     = {$urandom, $urandom};
    is_sub   = ~sub;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (!out_valid && edges < 20) begin step(); edges++; end
  endtask

  task automatic run_op(input vec_t v, input int hold, input string tag);
    int edges;
    out_ready = 1'b0;
    issue(v.a, v.b, v.sub);
    wait_done(edges);
    // accept cycle counted as cycle 0; out_valid must appear in cycle 3
    chk({tag, "_valid_cycle"}, edges + 1, 3);
    repeat (hold) step();
    chk({tag, "_result"}, result, v.res);
    chk({tag, "_carry"}, carry_out, v.co);
    chk({tag, "_ovf"}, overflow, v.ov);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, out_valid, 1'b0);
  endtask

  initial begin
    vec_t        tbl[7];
    vec_t        q[$];
    vec_t        e, ops[4];
    logic [63:0] r_hold;
    logic        c_hold, o_hold, seen, acc;
    int          edges, got, accepted, last_t, t;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; is_sub = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", result, 64'd0);
    chk("rst_carry", carry_out, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    tbl[0] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
    tbl[1] = '{64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    tbl[2] = '{64'h5, 64'h3, 1'b1, 64'h2, 1'b0, 1'b0};
    tbl[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    tbl[4] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
    tbl[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    tbl[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) run_op(tbl[i], 0, $sformatf("tbl%0d", i));

    // Backpressure: outputs frozen for 5 cycles with out_ready low
    e = model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
    issue(e.a, e.b, e.sub);
    wait_done(edges);
    chk("bp_result", result, e.res);
    r_hold = result; c_hold = carry_out; o_hold = overflow;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid_hold", out_valid, 1'b1);
      chk("bp_result_hold", result, r_hold);
      chk("bp_flags_hold", {62'd0, carry_out, overflow}, {62'd0, c_hold, o_hold});
      chk("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_valid_drop", out_valid, 1'b0);
    chk("bp_in_ready_back", in_ready, 1'b1);

    // Asynchronous reset while in HI; the aborted op leaves c_mid = 1 behind
    issue(64'h0000_0001_FFFF_FFFF, 64'h2, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    chk("rsthi_result", result, 64'd0);
    chk("rsthi_out_valid", out_valid, 1'b0);
    chk("rsthi_busy", busy, 1'b0);
    chk("rsthi_in_ready", in_ready, 1'b1);
    chk("rsthi_flags", {62'd0, carry_out, overflow}, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    run_op(model(64'h1, 64'h1, 1'b0), 0, "after_rst");

    // Flush during LO: no out_valid pulse follows
    issue(64'h3, 64'h4, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", busy, 1'b0);
    seen = out_valid;
    for (int i = 0; i < 4; i++) begin step(); seen |= out_valid; end
    chk("flush_no_valid", seen, 1'b0);
    run_op(model(64'h1, 64'h1, 1'b0), 0, "after_flush");

    // Flush has priority over a request in IDLE
    op_a = 64'h9; op_b = 64'h9; is_sub = 1'b0; in_valid = 1'b1; flush = 1'b1;
    #1;
    chk("flushpri_in_ready", in_ready, 1'b0);
    step();
    chk("flushpri_busy", busy, 1'b0);
    in_valid = 1'b0; flush = 1'b0;
    step();

    // Back-to-back with out_ready held high
    for (int i = 0; i < 4; i++) ops[i] = model({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    got = 0; accepted = 0; last_t = -1; t = 0;
    out_ready = 1'b1;
    op_a = ops[0].a; op_b = ops[0].b; is_sub = ops[0].sub; in_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      if (out_valid) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("b2b_result", result, e.res);
          chk("b2b_carry", carry_out, e.co);
          chk("b2b_ovf", overflow, e.ov);
        end else begin
          chk("b2b_unexpected_valid", 64'd1, 64'd0);
        end
        if (last_t >= 0) chk("b2b_interval", t - last_t, 4);
        last_t = t;
        got++;
      end
      acc = in_valid && in_ready;
      if (acc) q.push_back(ops[accepted]);
      step();
      t++;
      if (acc) begin
        accepted++;
        if (accepted < 4) begin
          op_a = ops[accepted].a; op_b = ops[accepted].b; is_sub = ops[accepted].sub;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("b2b_count", got, 4);
    out_ready = 1'b0;
    step();

    // Random operations with random consumer stall
    for (int i = 0; i < 20; i++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = (i % 4 == 0) ? ra : {$urandom, $urandom};
      run_op(model(ra, rb, 1'($urandom)), int'($urandom_range(0, 2)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
